// File: rtl/machine_ctrl_pkg.sv
// Shared types and constants for the machine-mode trap sequencer.
// Interrupt support is compiled in with MACHINE_CTRL_INTERRUPTS_EN.
package machine_ctrl_pkg;

    typedef enum logic [1:0] {
        ST_RESET       = 2'b00,
        ST_OPERATING   = 2'b01,
        ST_TRAP_TAKEN  = 2'b10,
        ST_TRAP_RETURN = 2'b11
    } state_t;

    localparam logic [1:0] PC_SRC_BOOT = 2'b00;
    localparam logic [1:0] PC_SRC_MEPC = 2'b01;
    localparam logic [1:0] PC_SRC_TRAP = 2'b10;
    localparam logic [1:0] PC_SRC_NEXT = 2'b11;

    localparam logic [3:0] CAUSE_INSTR_MISALIGNED = 4'd0;
    localparam logic [3:0] CAUSE_ILLEGAL_INSTR    = 4'd2;
    localparam logic [3:0] CAUSE_BREAKPOINT       = 4'd3;
    localparam logic [3:0] CAUSE_LOAD_MISALIGNED  = 4'd4;
    localparam logic [3:0] CAUSE_STORE_MISALIGNED = 4'd6;
    localparam logic [3:0] CAUSE_ECALL_M          = 4'd11;

    localparam logic [3:0] IRQ_MSI = 4'd3;
    localparam logic [3:0] IRQ_MTI = 4'd7;
    localparam logic [3:0] IRQ_MEI = 4'd11;

    typedef struct packed {
        logic       valid;
        logic [3:0] cause;
        logic       i_or_e;
        logic       misaligned;
    } trap_info_t;

    // Only these exception codes make mtval capture the faulting address.
    function automatic logic is_misaligned_cause(input logic [3:0] cause);
        return (cause == CAUSE_INSTR_MISALIGNED) ||
               (cause == CAUSE_LOAD_MISALIGNED)  ||
               (cause == CAUSE_STORE_MISALIGNED);
    endfunction

endpackage

// File: rtl/machine_ctrl_fsm_trap_prio_enc.sv
// Combinational trap priority encoder: picks the winning interrupt or exception.
// Interrupt arbitration exists only when MACHINE_CTRL_INTERRUPTS_EN is defined.
module trap_prio_enc
    import machine_ctrl_pkg::*;
(
    input  logic       illegal_instr,
    input  logic       misaligned_instr,
    input  logic       misaligned_load,
    input  logic       misaligned_store,
    input  logic       ecall,
    input  logic       ebreak,
    input  logic       mie,
    input  logic       meie,
    input  logic       mtie,
    input  logic       msie,
    input  logic       meip,
    input  logic       mtip,
    input  logic       msip,
    output trap_info_t trap
);

    logic       exc_valid;
    logic [3:0] exc_cause;
    logic       irq_valid;
    logic [3:0] irq_cause;

    always_comb begin
        exc_valid = 1'b1;
        exc_cause = CAUSE_INSTR_MISALIGNED;
        if (misaligned_instr)      exc_cause = CAUSE_INSTR_MISALIGNED;
        else if (illegal_instr)    exc_cause = CAUSE_ILLEGAL_INSTR;
        else if (ebreak)           exc_cause = CAUSE_BREAKPOINT;
        else if (ecall)            exc_cause = CAUSE_ECALL_M;
        else if (misaligned_load)  exc_cause = CAUSE_LOAD_MISALIGNED;
        else if (misaligned_store) exc_cause = CAUSE_STORE_MISALIGNED;
        else                       exc_valid = 1'b0;
    end

`ifdef MACHINE_CTRL_INTERRUPTS_EN
    always_comb begin
        irq_valid = mie;
        irq_cause = IRQ_MEI;
        if (meie && meip)      irq_cause = IRQ_MEI;
        else if (msie && msip) irq_cause = IRQ_MSI;
        else if (mtie && mtip) irq_cause = IRQ_MTI;
        else                   irq_valid = 1'b0;
    end
`else
    logic unused_irq;
    assign unused_irq = ^{mie, meie, mtie, msie, meip, mtip, msip};
    assign irq_valid  = 1'b0;
    assign irq_cause  = 4'd0;
`endif

    // Any enabled interrupt outranks every synchronous exception.
    always_comb begin
        trap = '0;
        if (irq_valid) begin
            trap.valid  = 1'b1;
            trap.cause  = irq_cause;
            trap.i_or_e = 1'b1;
        end else if (exc_valid) begin
            trap.valid      = 1'b1;
            trap.cause      = exc_cause;
            trap.misaligned = is_misaligned_cause(exc_cause);
        end
    end

endmodule

// File: rtl/machine_ctrl_fsm.sv
// Machine-mode trap sequencer: sequences trap entry and MRET one cycle at a time.
// Define MACHINE_CTRL_INTERRUPTS_EN to enable interrupt detection.
module machine_ctrl_fsm
    import machine_ctrl_pkg::*;
#(
    parameter logic [1:0] RESET_VECTOR_SEL = 2'b00
) (
    input  logic       clk_in,
    input  logic       rst_in,
    input  logic       stall_in,
    input  logic       illegal_instr_in,
    input  logic       misaligned_instr_in,
    input  logic       misaligned_load_in,
    input  logic       misaligned_store_in,
    input  logic       ecall_in,
    input  logic       ebreak_in,
    input  logic       mret_in,
    input  logic       mie_in,
    input  logic       meie_in,
    input  logic       mtie_in,
    input  logic       msie_in,
    input  logic       meip_in,
    input  logic       mtip_in,
    input  logic       msip_in,
    output logic       set_cause_out,
    output logic       set_epc_out,
    output logic [3:0] cause_out,
    output logic       i_or_e_out,
    output logic       misaligned_exception_out,
    output logic       mie_clear_out,
    output logic       mie_set_out,
    output logic       instret_inc_out,
    output logic       flush_out,
    output logic [1:0] pc_src_out
);

    state_t     state_q, state_d;
    trap_info_t trap;
    logic       take_trap;
    logic [3:0] cause_q;
    logic       i_or_e_q;
    logic       misaligned_q;

    trap_prio_enc u_prio (
        .illegal_instr    (illegal_instr_in),
        .misaligned_instr (misaligned_instr_in),
        .misaligned_load  (misaligned_load_in),
        .misaligned_store (misaligned_store_in),
        .ecall            (ecall_in),
        .ebreak           (ebreak_in),
        .mie              (mie_in),
        .meie             (meie_in),
        .mtie             (mtie_in),
        .msie             (msie_in),
        .meip             (meip_in),
        .mtip             (mtip_in),
        .msip             (msip_in),
        .trap             (trap)
    );

    assign take_trap = (state_q == ST_OPERATING) && !stall_in && trap.valid;

    always_ff @(posedge clk_in or negedge rst_in) begin
        if (!rst_in) begin
            state_q      <= ST_RESET;
            cause_q      <= 4'd0;
            i_or_e_q     <= 1'b0;
            misaligned_q <= 1'b0;
        end else begin
            state_q <= state_d;
            if (take_trap) begin
                cause_q      <= trap.cause;
                i_or_e_q     <= trap.i_or_e;
                misaligned_q <= trap.misaligned;
            end
        end
    end

    // Pulses decode from the registered state, so async reset clears them at once.
    always_comb begin
        state_d         = state_q;
        set_cause_out   = 1'b0;
        set_epc_out     = 1'b0;
        mie_clear_out   = 1'b0;
        mie_set_out     = 1'b0;
        instret_inc_out = 1'b0;
        flush_out       = 1'b0;
        pc_src_out      = RESET_VECTOR_SEL;
        case (state_q)
            ST_RESET: begin
                state_d = ST_OPERATING;
            end
            ST_OPERATING: begin
                pc_src_out = PC_SRC_NEXT;
                if (!stall_in) begin
                    if (trap.valid)   state_d = ST_TRAP_TAKEN;
                    else if (mret_in) state_d = ST_TRAP_RETURN;
                    else              instret_inc_out = 1'b1;
                end
            end
            ST_TRAP_TAKEN: begin
                state_d       = ST_OPERATING;
                set_cause_out = 1'b1;
                set_epc_out   = 1'b1;
                mie_clear_out = 1'b1;
                flush_out     = 1'b1;
                pc_src_out    = PC_SRC_TRAP;
            end
            ST_TRAP_RETURN: begin
                state_d     = ST_OPERATING;
                mie_set_out = 1'b1;
                flush_out   = 1'b1;
                pc_src_out  = PC_SRC_MEPC;
            end
        endcase
    end

    assign cause_out                = cause_q;
    assign i_or_e_out               = i_or_e_q;
    assign misaligned_exception_out = misaligned_q;

endmodule
